// File: rtl/fir_symmetric_pkg.sv
// Shared widths, tap count and the unique half of the symmetric coefficient set
// for the 21-tap linear-phase bandpass FIR.
package fir_symmetric_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int COEF_W_DEF = 16;
  localparam int OUT_W_DEF  = 32;
  localparam int NTAPS_DEF  = 21;
  localparam int NUNIQ_DEF  = (NTAPS_DEF + 1) / 2;

  typedef logic signed [COEF_W_DEF-1:0] coef_arr_t [NUNIQ_DEF];

  // h[0..9] pair with h[20..11]; h[10] is the centre tap. The taps sum to zero.
  localparam coef_arr_t H_COEFS = '{
    -16'sd120,  -16'sd210,  -16'sd180,   16'sd95,    16'sd560, 16'sd910,
     16'sd700,  -16'sd190,  -16'sd1450, -16'sd2550,  16'sd4870
  };

endpackage

// File: rtl/fir_preadd_mult.sv
// One symmetric tap pair: registers x[k] + x[N-1-k] at full width and presents
// its product with the pair's coefficient to the top-level adder tree.
module fir_preadd_mult
  import fir_symmetric_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int COEF_W = COEF_W_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic signed [DATA_W-1:0]       a_i,
  input  logic signed [DATA_W-1:0]       b_i,
  input  logic signed [COEF_W-1:0]       coef_i,
  output logic signed [DATA_W+COEF_W:0]  prod_o
);

  localparam int PROD_W = DATA_W + COEF_W + 1;

  logic signed [DATA_W:0] pre_d;
  logic signed [DATA_W:0] pre_q;

  always_comb begin
    pre_d = {a_i[DATA_W-1], a_i} + {b_i[DATA_W-1], b_i};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  assign prod_o = PROD_W'(pre_q) * PROD_W'(coef_i);

endmodule

// File: rtl/fir_symmetric_filter.sv
// 21-tap type-I symmetric FIR: delay line, registered pre-adds, combinational
// multiply/adder tree, saturating registered output. Latency 2, one sample/clock.
module fir_symmetric_filter
  import fir_symmetric_pkg::*;
#(
  parameter int        DATA_W = DATA_W_DEF,
  parameter int        COEF_W = COEF_W_DEF,
  parameter int        OUT_W  = OUT_W_DEF,
  parameter int        NTAPS  = NTAPS_DEF,
  parameter coef_arr_t COEFS  = H_COEFS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] sample_in,
  output logic signed [OUT_W-1:0]  filtered_out
);

  localparam int NPAIR  = (NTAPS - 1) / 2;
  localparam int CTR    = NPAIR;
  localparam int PROD_W = DATA_W + COEF_W + 1;
  localparam int ACC_W  = PROD_W + $clog2(NPAIR + 1) + 1;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [DATA_W-1:0] x_q [NTAPS];
  logic signed [DATA_W:0]   ctr_q;
  logic signed [PROD_W-1:0] prod [NPAIR];
  logic signed [PROD_W-1:0] ctr_prod;
  logic signed [ACC_W-1:0]  acc_d;
  logic signed [OUT_W-1:0]  out_d;

  // x_q[0] holds the newest sample; reset discards the whole history.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NTAPS; i++) x_q[i] <= '0;
      ctr_q <= '0;
    end else begin
      x_q[0] <= sample_in;
      for (int i = 1; i < NTAPS; i++) x_q[i] <= x_q[i-1];
      ctr_q <= {x_q[CTR][DATA_W-1], x_q[CTR]};
    end
  end

  for (genvar k = 0; k < NPAIR; k++) begin : g_pair
    fir_preadd_mult #(
      .DATA_W (DATA_W),
      .COEF_W (COEF_W)
    ) u_pair (
      .clk    (clk),
      .rst    (rst),
      .a_i    (x_q[k]),
      .b_i    (x_q[NTAPS-1-k]),
      .coef_i (COEFS[k]),
      .prod_o (prod[k])
    );
  end

  assign ctr_prod = PROD_W'(ctr_q) * PROD_W'(COEFS[CTR]);

  always_comb begin
    acc_d = ACC_W'(ctr_prod);
    for (int k = 0; k < NPAIR; k++) acc_d = acc_d + ACC_W'(prod[k]);
  end

  // Clamp rather than wrap when the full-precision sum leaves the output range.
  always_comb begin
    if (acc_d > ACC_MAX) begin
      out_d = {1'b0, {(OUT_W-1){1'b1}}};
    end else if (acc_d < ACC_MIN) begin
      out_d = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      out_d = acc_d[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      filtered_out <= '0;
    end else begin
      filtered_out <= out_d;
    end
  end

endmodule

// File: tb/tb_fir_symmetric_filter.sv
// Bench for fir_symmetric_filter: directed and random samples against a direct
// convolution model, plus a second instance with all-32767 taps for clamping.
module tb_fir_symmetric_filter;
  import fir_symmetric_pkg::*;

  localparam coef_arr_t SAT_COEFS = '{default: 16'sd32767};

  // clock / reset
  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic signed [15:0] sample_in = '0;
  logic signed [31:0] filtered_out;
  logic signed [31:0] sat_out;

  always #5 clk = ~clk;

  fir_symmetric_filter dut (
    .clk          (clk),
    .rst          (rst),
    .sample_in    (sample_in),
    .filtered_out (filtered_out)
  );

  fir_symmetric_filter #(.COEFS(SAT_COEFS)) dut_sat (
    .clk          (clk),
    .rst          (rst),
    .sample_in    (sample_in),
    .filtered_out (sat_out)
  );

  // reference model: full 21-tap impulse responses and sample history
  int h_def [21] = '{-120, -210, -180, 95, 560, 910, 700, -190, -1450, -2550, 4870,
                     -2550, -1450, -190, 700, 910, 560, 95, -180, -210, -120};
  int h_sat [21] = '{default: 32767};
  int hist  [21] = '{default: 0};

  logic signed [31:0] exp_q[$];
  logic signed [31:0] exp_sat_q[$];
  logic signed [31:0] e_def, e_sat, last_out, last_sat;
  logic signed [31:0] rec [32];
  int checks = 0;
  int errors = 0;

  function automatic logic signed [31:0] conv(input int h[21]);
    longint acc = 0;
    for (int k = 0; k < 21; k++) acc += longint'(h[k]) * longint'(hist[k]);
    if (acc > 64'sd2147483647) return 32'sh7fffffff;
    if (acc < -64'sd2147483648) return 32'sh80000000;
    return 32'(acc);
  endfunction

  // scoreboard
  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // driver: one clock with the given reset level and sample
  task automatic step(input logic r, input int s);
    rst       = r;
    sample_in = 16'(s);
    @(posedge clk);
    if (!r) begin
      for (int k = 0; k < 21; k++) hist[k] = 0;
      exp_q.delete();
      exp_sat_q.delete();
      repeat (2) begin
        exp_q.push_back('0);
        exp_sat_q.push_back('0);
      end
      e_def = '0;
      e_sat = '0;
    end else begin
      e_def = exp_q.pop_front();
      e_sat = exp_sat_q.pop_front();
      for (int k = 20; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = s;
      exp_q.push_back(conv(h_def));
      exp_sat_q.push_back(conv(h_sat));
    end
    #1;
    check("model_out", filtered_out, e_def);
    check("model_sat_out", sat_out, e_sat);
    last_out = filtered_out;
    last_sat = sat_out;
  endtask

  function automatic int rnd16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  initial begin
    // reset at start
    step(1'b0, rnd16());
    check("reset_out", last_out, 32'sd0);

    // unit impulse
    step(1'b1, 1);
    rec[0] = last_out;
    for (int j = 1; j < 25; j++) begin
      step(1'b1, 0);
      rec[j] = last_out;
    end
    check("impulse_lat0", rec[0], 32'sd0);
    check("impulse_lat1", rec[1], 32'sd0);
    for (int j = 0; j < 21; j++) check("impulse_tap", rec[j+2], 32'(h_def[j]));
    check("impulse_tail", rec[23], 32'sd0);

    // scaled negative full-scale impulse
    step(1'b0, 0);
    step(1'b1, -32768);
    rec[0] = last_out;
    for (int j = 1; j < 25; j++) begin
      step(1'b1, 0);
      rec[j] = last_out;
    end
    check("scaled_first", rec[2], 32'sd3932160);
    check("scaled_centre", rec[12], -32'sd159580160);
    check("scaled_last", rec[22], 32'sd3932160);

    // DC input
    step(1'b0, 0);
    for (int j = 0; j < 30; j++) begin
      step(1'b1, 1000);
      rec[j] = last_out;
    end
    check("dc_first", rec[2], -32'sd120000);
    for (int j = 22; j < 30; j++) check("dc_zero", rec[j], 32'sd0);

    // mid-stream reset discards history
    for (int j = 0; j < 10; j++) step(1'b1, rnd16());
    step(1'b0, rnd16());
    check("midreset_out", last_out, 32'sd0);
    for (int j = 0; j < 24; j++) begin
      step(1'b1, 0);
      check("midreset_no_history", last_out, 32'sd0);
    end

    // random stream
    for (int j = 0; j < 256; j++) step(1'b1, rnd16());

    // saturation with all-32767 coefficients
    step(1'b0, 0);
    for (int j = 0; j < 30; j++) begin
      step(1'b1, 32767);
      rec[j] = last_sat;
    end
    check("sat_partial", rec[3], 32'sd2147352578);
    for (int j = 4; j < 30; j++) check("sat_clamp", rec[j], 32'sh7fffffff);
    check("sat_default_dc", last_out, 32'sd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
